// File: rtl/potential_adder_scheduler.sv
// Round-robin scheduler sharing one floating-point potential adder among four neurons.
// Stores each neuron's potential, issues operands, waits out the adder latency and writes back.
//
// state   | meaning
// CONFIG  | one-cycle adder configuration load after reset
// IDLE    | service a pending timestep clear, otherwise arbitrate requests
// ISSUE   | grant the winner and present its operands to the adder
// WAIT    | count down the adder latency
// CAPTURE | write back the adder result and spike flag
module potential_adder_scheduler #(
    parameter int unsigned ADDER_LAT      = 2,
    parameter logic [31:0] INIT_POTENTIAL = 32'h0000_0000
) (
    input  logic         CLK_Sched,
    input  logic         clear_sched,
    input  logic [3:0]   req,
    input  logic [127:0] req_weight,
    input  logic         timestep_start,
    output logic [3:0]   grant,
    output logic         adder_set,
    output logic         adder_clear,
    output logic [31:0]  adder_weight,
    output logic [31:0]  adder_potential,
    input  logic [31:0]  adder_result,
    input  logic         adder_spike,
    output logic [3:0]   spike_vec,
    input  logic [1:0]   rd_sel,
    output logic [31:0]  potential_rd,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_CONFIG,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ADDER_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] pot [4];
    logic [1:0]  winner_q;
    logic [1:0]  last_winner_q;
    logic [31:0] weight_q;
    logic [3:0]  cnt_q;
    logic [3:0]  spike_vec_q;
    logic        pending_q;

    logic        ts_pend;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        pick_valid;
    logic        op_active;

    assign ts_pend = pending_q | timestep_start;

    // Scan offsets from high to low so the closest requester after last_winner wins.
    always_comb begin
        pick       = 2'd0;
        cand       = 2'd0;
        pick_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            cand = last_winner_q + 2'(k) + 2'd1;
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CONFIG:  state_d = S_IDLE;
            S_IDLE:    if (!ts_pend && pick_valid) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (cnt_q == 4'd0) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_CONFIG;
        endcase
    end

    always_comb begin
        op_active       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
        grant           = 4'd0;
        if (state_q == S_ISSUE && !clear_sched) grant[winner_q] = 1'b1;
        adder_set       = clear_sched || (state_q == S_CONFIG);
        adder_clear     = clear_sched || ((state_q == S_IDLE) && ts_pend);
        done            = (state_q == S_CAPTURE) && !clear_sched;
        busy            = (state_q != S_IDLE);
        adder_weight    = op_active ? weight_q : 32'd0;
        adder_potential = op_active ? pot[winner_q] : 32'd0;
    end

    always_ff @(posedge CLK_Sched) begin
        if (clear_sched) begin
            state_q       <= S_CONFIG;
            for (int i = 0; i < 4; i++) pot[i] <= INIT_POTENTIAL;
            winner_q      <= 2'd0;
            last_winner_q <= 2'd3;
            weight_q      <= 32'd0;
            cnt_q         <= 4'd0;
            spike_vec_q   <= 4'd0;
            pending_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (timestep_start && state_q != S_IDLE) pending_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (ts_pend) begin
                        spike_vec_q <= 4'd0;
                        pending_q   <= 1'b0;
                    end else if (pick_valid) begin
                        winner_q <= pick;
                        weight_q <= req_weight[{pick, 5'd0} +: 32];
                    end
                end
                S_ISSUE: cnt_q <= LAT_M1;
                S_WAIT:  if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                S_CAPTURE: begin
                    pot[winner_q]         <= adder_result;
                    spike_vec_q[winner_q] <= spike_vec_q[winner_q] | adder_spike;
                    last_winner_q         <= winner_q;
                end
                default: ;
            endcase
        end
    end

    assign spike_vec    = spike_vec_q;
    assign potential_rd = pot[rd_sel];

endmodule
